// File: rtl/shftreg_rr_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : shftreg_rr_ctrl_if
// Description : Request/serial bundle for shftreg_rr_ctrl. Two word-level
//               requesters (valid/ready/data) and one serial output stream.
//               master = producer/consumer side, slave = controller side.
// Revision    : 1.0 - initial release
// ============================================================================
interface shftreg_rr_ctrl_if #(
  parameter int LENGTH = 6
);
  logic              req0_valid;
  logic [LENGTH-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [LENGTH-1:0] req1_data;
  logic              req1_ready;
  logic              s_out;
  logic              s_valid;
  logic              s_ready;
  logic              s_first;
  logic              s_last;
  logic              s_src;

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, s_ready,
    input  req0_ready, req1_ready, s_out, s_valid, s_first, s_last, s_src
  );

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, s_ready,
    output req0_ready, req1_ready, s_out, s_valid, s_first, s_last, s_src
  );
endinterface
`default_nettype wire

// File: rtl/shftreg_rr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : shftreg_rr_ctrl
// Description : Two-requester round-robin controller feeding an MSB-first
//               shift register. Grants one word at a time, loads it in
//               parallel and shifts it out under downstream back-pressure,
//               tagging first/last bit and source.
//               Optional macro SHFTREG_RR_CTRL_GAP_EN inserts GAP_CYCLES idle
//               cycles (plus one IDLE cycle) after every word.
// Revision    : 1.0 - initial release
// ============================================================================
module shftreg_rr_ctrl #(
  parameter int LENGTH     = 6,
  parameter int GAP_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  shftreg_rr_ctrl_if.slave    bus,
  output logic                busy
);

  localparam int              CNT_W    = $clog2(LENGTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(LENGTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1
`ifdef SHFTREG_RR_CTRL_GAP_EN
    , ST_GAP = 2'd2
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [LENGTH-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              last_src_q, last_src_d;
  logic              src_q, src_d;

  logic last_bit;
  logic load_slot;
  logic grant0, grant1;
  logic hs0, hs1;

`ifdef SHFTREG_RR_CTRL_GAP_EN
  localparam int              GAP_W    = $clog2(GAP_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
`else
  // The gap length only matters when the gap state is built.
  logic unused_gap_cycles;
  assign unused_gap_cycles = (GAP_CYCLES > 0);
`endif

  // Arbitration and load window: grant is purely a function of valids and
  // the previous winner; ready is additionally held low while in reset.
  always_comb begin
    last_bit = (state_q == ST_SHIFT) && (bit_cnt_q == LAST_BIT);
`ifdef SHFTREG_RR_CTRL_GAP_EN
    load_slot = (state_q == ST_IDLE);
`else
    load_slot = (state_q == ST_IDLE) || (last_bit && bus.s_ready);
`endif
    grant0 = bus.req0_valid && (!bus.req1_valid || last_src_q);
    grant1 = bus.req1_valid && (!bus.req0_valid || !last_src_q);
    hs0    = grant0 && load_slot && rst_n;
    hs1    = grant1 && load_slot && rst_n;
  end

  assign bus.req0_ready = grant0 && load_slot && rst_n;
  assign bus.req1_ready = grant1 && load_slot && rst_n;

  assign bus.s_valid = (state_q == ST_SHIFT);
  assign bus.s_out   = sreg_q[LENGTH-1];
  assign bus.s_first = (state_q == ST_SHIFT) && (bit_cnt_q == '0);
  assign bus.s_last  = last_bit;
  assign bus.s_src   = src_q;
  assign busy        = (state_q != ST_IDLE);

  // Next-state: shift on accepted bits, leave SHIFT after the last bit, and
  // let a handshake override everything with a fresh parallel load.
  always_comb begin
    state_d    = state_q;
    sreg_d     = sreg_q;
    bit_cnt_d  = bit_cnt_q;
    last_src_d = last_src_q;
    src_d      = src_q;
`ifdef SHFTREG_RR_CTRL_GAP_EN
    gap_cnt_d  = gap_cnt_q;
`endif
    case (state_q)
      ST_IDLE: ;
      ST_SHIFT: begin
        if (bus.s_ready) begin
          sreg_d    = {sreg_q[LENGTH-2:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (last_bit) begin
            bit_cnt_d = '0;
`ifdef SHFTREG_RR_CTRL_GAP_EN
            state_d   = ST_GAP;
            gap_cnt_d = '0;
`else
            state_d   = ST_IDLE;
`endif
          end
        end
      end
`ifdef SHFTREG_RR_CTRL_GAP_EN
      ST_GAP: begin
        gap_cnt_d = gap_cnt_q + 1'b1;
        if (gap_cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
    if (hs0 || hs1) begin
      sreg_d     = hs1 ? bus.req1_data : bus.req0_data;
      src_d      = hs1;
      last_src_d = hs1;
      bit_cnt_d  = '0;
      state_d    = ST_SHIFT;
    end
  end

  // State register with asynchronous reset; a reset mid-word drops the word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      sreg_q     <= '0;
      bit_cnt_q  <= '0;
      last_src_q <= 1'b1;
      src_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sreg_q     <= sreg_d;
      bit_cnt_q  <= bit_cnt_d;
      last_src_q <= last_src_d;
      src_q      <= src_d;
    end
  end

`ifdef SHFTREG_RR_CTRL_GAP_EN
  // Gap cycle counter, only meaningful while in the gap state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_cnt_q <= '0;
    end else begin
      gap_cnt_q <= gap_cnt_d;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_shftreg_rr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_shftreg_rr_ctrl
// Description : Self-checking bench for shftreg_rr_ctrl. A word-level model
//               (queue of granted words, round-robin rule) predicts every
//               serial bit; directed steps cover reset, latency, contention,
//               stalls, mid-word reset and inter-word gaps, then random
//               traffic runs against the same model.
//               Honours SHFTREG_RR_CTRL_GAP_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shftreg_rr_ctrl;
  localparam int LENGTH     = 6;
  localparam int GAP_CYCLES = 2;
`ifdef SHFTREG_RR_CTRL_GAP_EN
  localparam int EXP_GAP  = GAP_CYCLES + 1;
  localparam int EXP_WAIT = LENGTH + GAP_CYCLES;
`else
  localparam int EXP_GAP  = 0;
  localparam int EXP_WAIT = LENGTH - 1;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic busy;

  shftreg_rr_ctrl_if #(.LENGTH(LENGTH)) bus ();

  shftreg_rr_ctrl #(.LENGTH(LENGTH), .GAP_CYCLES(GAP_CYCLES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic              src;
    logic [LENGTH-1:0] data;
  } word_t;

  word_t             exp_q[$];
  logic              src_log[$];
  logic [LENGTH-1:0] data_log[$];
  int                gap_log[$];
  int                n_checks = 0;
  int                n_fail   = 0;
  int                hs_count = 0;
  int                bit_idx  = 0;
  logic              m_last_src = 1'b1;
  bit                after_word = 1'b0;
  int                idle_run   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    src_log.delete();
    data_log.delete();
    gap_log.delete();
    after_word = 1'b0;
    idle_run   = 0;
    hs_count   = 0;
  endtask

  // Word-level reference: every handshake enqueues the granted word, every
  // accepted serial bit is compared against the head word, MSB first.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      bit_idx    = 0;
      m_last_src = 1'b1;
      after_word = 1'b0;
    end else begin
      word_t w;
      logic  win;
      if (bus.s_valid) begin
        if (bit_idx == 0 && after_word) begin
          gap_log.push_back(idle_run);
          after_word = 1'b0;
        end
        if (exp_q.size() == 0) begin
          check("orphan_bit", 32'd1, 32'd0);
        end else begin
          w = exp_q[0];
          check("s_out",   bus.s_out,   w.data[LENGTH-1-bit_idx]);
          check("s_first", bus.s_first, (bit_idx == 0));
          check("s_last",  bus.s_last,  (bit_idx == LENGTH-1));
          check("s_src",   bus.s_src,   w.src);
          if (bus.s_ready) begin
            bit_idx++;
            if (bit_idx == LENGTH) begin
              void'(exp_q.pop_front());
              src_log.push_back(w.src);
              data_log.push_back(w.data);
              bit_idx    = 0;
              after_word = 1'b1;
              idle_run   = 0;
            end
          end
        end
      end else if (after_word) begin
        idle_run++;
      end
      check("ready0_needs_valid", bus.req0_ready & ~bus.req0_valid, 1'b0);
      check("ready1_needs_valid", bus.req1_ready & ~bus.req1_valid, 1'b0);
      if (!busy && (bus.req0_valid || bus.req1_valid)) begin
        check("idle_offers_ready", bus.req0_ready | bus.req1_ready, 1'b1);
      end
      if (bus.req0_ready || bus.req1_ready) begin
        if (bus.req0_valid && bus.req1_valid) win = ~m_last_src;
        else                                  win = bus.req1_valid;
        check("grant", {bus.req1_ready, bus.req0_ready}, win ? 2'b10 : 2'b01);
        w.src  = win;
        w.data = win ? bus.req1_data : bus.req0_data;
        exp_q.push_back(w);
        m_last_src = win;
        hs_count++;
      end
    end
  end

  task automatic wait_ready(input int which, input string tag);
    bit got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ((which == 0 && bus.req0_ready) || (which == 1 && bus.req1_ready)) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check(tag, 32'd0, 32'd1);
  endtask

  task automatic drain(input string tag);
    bit done = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.s_ready    = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    check(tag, done, 1'b1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LENGTH-1:0] w;
    int                wait_lo;
    bit                got;
    bus.req0_valid = 1'b1;
    bus.req0_data  = 6'h3F;
    bus.req1_valid = 1'b1;
    bus.req1_data  = 6'h01;
    bus.s_ready    = 1'b1;

    // Reset values while both requesters are already waiting
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_valid", bus.s_valid,    1'b0);
    check("rst_s_out",   bus.s_out,      1'b0);
    check("rst_s_first", bus.s_first,    1'b0);
    check("rst_s_last",  bus.s_last,     1'b0);
    check("rst_busy",    busy,           1'b0);
    check("rst_ready0",  bus.req0_ready, 1'b0);
    check("rst_ready1",  bus.req1_ready, 1'b0);

    // Contention from reset: req0, req1, req0 with no idle cycles
    rst_n = 1'b1;
    got   = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (hs_count >= 3) begin
        got = 1'b1;
        break;
      end
    end
    check("cont_3_handshakes", got, 1'b1);
    drain("cont_drain");
    check("cont_words", data_log.size(), 3);
    if (data_log.size() == 3) begin
      check("cont_w0", data_log[0], 6'h3F);
      check("cont_w1", data_log[1], 6'h01);
      check("cont_w2", data_log[2], 6'h3F);
      check("cont_s0", src_log[0],  1'b0);
      check("cont_s1", src_log[1],  1'b1);
      check("cont_s2", src_log[2],  1'b0);
    end
    check("cont_gaps", gap_log.size(), 2);
    if (gap_log.size() == 2) begin
      check("cont_gap0", gap_log[0], EXP_GAP);
      check("cont_gap1", gap_log[1], EXP_GAP);
    end

    // Single word 101100: first bit one cycle after the handshake edge
    clear_logs();
    w = 6'b101100;
    bus.req0_data  = w;
    bus.req0_valid = 1'b1;
    @(negedge clk);
    check("sw_ready0", bus.req0_ready, 1'b1);
    @(posedge clk);
    #1;
    bus.req0_valid = 1'b0;
    for (int i = 0; i < LENGTH; i++) begin
      @(negedge clk);
      check("sw_valid", bus.s_valid, 1'b1);
      check("sw_bit",   bus.s_out,   w[LENGTH-1-i]);
      check("sw_first", bus.s_first, (i == 0));
      check("sw_last",  bus.s_last,  (i == LENGTH-1));
      check("sw_src",   bus.s_src,   1'b0);
    end
    @(negedge clk);
    check("sw_busy_after",  busy,        1'b0);
    check("sw_valid_after", bus.s_valid, 1'b0);
    drain("sw_drain");

    // Back-pressure: three stall cycles on bit 2 of 110010
    clear_logs();
    w = 6'b110010;
    bus.req0_data  = w;
    bus.req0_valid = 1'b1;
    wait_ready(0, "bp_handshake");
    @(posedge clk);
    #1;
    bus.req0_valid = 1'b0;
    for (int i = 0; i < LENGTH; i++) begin
      if (i == 2) begin
        bus.s_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("bp_stall_valid", bus.s_valid, 1'b1);
          check("bp_stall_bit",   bus.s_out,   w[3]);
          check("bp_stall_first", bus.s_first, 1'b0);
          check("bp_stall_last",  bus.s_last,  1'b0);
          @(posedge clk);
          #1;
        end
        bus.s_ready = 1'b1;
      end
      @(negedge clk);
      check("bp_bit", bus.s_out, w[LENGTH-1-i]);
      @(posedge clk);
      #1;
    end
    drain("bp_drain");
    check("bp_words", data_log.size(), 1);
    if (data_log.size() == 1) check("bp_word", data_log[0], 6'b110010);

    // Two consecutive req0 words: ready held off until the load slot
    clear_logs();
    bus.req0_data  = 6'h2A;
    bus.req0_valid = 1'b1;
    wait_ready(0, "b2b_first_hs");
    @(posedge clk);
    #1;
    bus.req0_data = 6'h15;
    wait_lo = 0;
    got     = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.req0_ready) begin
        got = 1'b1;
        break;
      end
      wait_lo++;
    end
    check("b2b_second_hs", got, 1'b1);
    check("b2b_ready_low_cycles", wait_lo, EXP_WAIT);
    @(posedge clk);
    #1;
    drain("b2b_drain");
    check("b2b_words", data_log.size(), 2);
    if (data_log.size() == 2) begin
      check("b2b_w0", data_log[0], 6'h2A);
      check("b2b_w1", data_log[1], 6'h15);
    end
    check("b2b_gaps", gap_log.size(), 1);
    if (gap_log.size() == 1) check("b2b_gap", gap_log[0], EXP_GAP);

    // Reset during bit 3 discards the word; the next req1 word starts clean
    bus.req1_data  = 6'h2D;
    bus.req1_valid = 1'b1;
    wait_ready(1, "mr_handshake");
    @(posedge clk);
    #1;
    bus.req1_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("mr_s_valid", bus.s_valid,    1'b0);
    check("mr_s_out",   bus.s_out,      1'b0);
    check("mr_s_first", bus.s_first,    1'b0);
    check("mr_s_last",  bus.s_last,     1'b0);
    check("mr_busy",    busy,           1'b0);
    check("mr_ready0",  bus.req0_ready, 1'b0);
    check("mr_ready1",  bus.req1_ready, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_logs();
    repeat (2) begin
      @(negedge clk);
      check("mr_no_resume", bus.s_valid, 1'b0);
    end
    @(posedge clk);
    #1;
    w = 6'b100111;
    bus.req1_data  = w;
    bus.req1_valid = 1'b1;
    wait_ready(1, "mr_new_hs");
    @(posedge clk);
    #1;
    bus.req1_valid = 1'b0;
    @(negedge clk);
    check("mr_new_first", bus.s_first, 1'b1);
    check("mr_new_src",   bus.s_src,   1'b1);
    check("mr_new_bit",   bus.s_out,   w[LENGTH-1]);
    drain("mr_drain");
    check("mr_words", data_log.size(), 1);
    if (data_log.size() == 1) check("mr_word", data_log[0], w);

    // Random traffic with random back-pressure and dropped requests
    clear_logs();
    for (int i = 0; i < 1500; i++) begin
      bus.req0_valid = ($urandom_range(0, 3) != 0);
      bus.req1_valid = ($urandom_range(0, 3) != 0);
      bus.req0_data  = LENGTH'($urandom);
      bus.req1_data  = LENGTH'($urandom);
      bus.s_ready    = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    drain("rand_drain");
    check("rand_words_seen", (data_log.size() > 50), 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
